// File: rtl/if_id_reg.sv
// IF/ID pipeline register: carries the fetched address and instruction word
// into decode, with run enable, hazard stall and branch/jump flush.
module if_id_reg #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           INST_WIDTH = 32,
  parameter logic [INST_WIDTH-1:0] NOP_INST   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [INST_WIDTH-1:0] inst_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic                  valid_o
);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [INST_WIDTH-1:0] r_inst;
  logic                  r_valid;

  logic w_flush;
  logic w_load;

  // A deasserted run enable masks both flush and stall; flush outranks stall.
  assign w_flush = start_i & flush_i;
  assign w_load  = start_i & ~flush_i & ~stall_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr  <= '0;
      r_inst  <= NOP_INST;
      r_valid <= 1'b0;
    end else if (w_flush) begin
      r_addr  <= '0;
      r_inst  <= NOP_INST;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_addr  <= addr_i;
      r_inst  <= inst_i;
      r_valid <= 1'b1;
    end
  end

  assign addr_o  = r_addr;
  assign inst_o  = r_inst;
  assign valid_o = r_valid;

endmodule

// File: tb/tb_if_id_reg.sv
// Self-checking bench for if_id_reg: directed scenarios plus randomized
// control/data traffic checked against a per-edge priority-rule model.
module tb_if_id_reg;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] addr_i;
  logic [31:0] inst_i;
  logic [31:0] addr_o;
  logic [31:0] inst_o;
  logic        valid_o;

  logic [31:0] exp_addr;
  logic [31:0] exp_inst;
  logic        exp_valid;

  int unsigned n_pass;
  int unsigned n_total;

  if_id_reg dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .stall_i (stall_i),
    .flush_i (flush_i),
    .addr_i  (addr_i),
    .inst_i  (inst_i),
    .addr_o  (addr_o),
    .inst_o  (inst_o),
    .valid_o (valid_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic drive(input logic st, input logic sl, input logic fl,
                       input logic [31:0] a, input logic [31:0] ins);
    start_i = st;
    stall_i = sl;
    flush_i = fl;
    addr_i  = a;
    inst_i  = ins;
  endtask

  // One rising edge; the model applies the rules to the inputs seen at it.
  task automatic tick();
    @(posedge clk_i);
    if (rst_i) begin
      exp_addr = '0; exp_inst = '0; exp_valid = 1'b0;
    end else if (!start_i) begin
      // hold
    end else if (flush_i) begin
      exp_addr = '0; exp_inst = '0; exp_valid = 1'b0;
    end else if (!stall_i) begin
      exp_addr = addr_i; exp_inst = inst_i; exp_valid = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h9abc_def0);
    exp_addr = '0; exp_inst = '0; exp_valid = 1'b0;
    #2;
    n_total++;
    if ({addr_o, inst_o, valid_o} !== {32'h0, 32'h0, 1'b0})
      $display("FAIL reset_no_edge: got %h/%h/%b expected 0/0/0", addr_o, inst_o, valid_o);
    else n_pass++;
    drive(1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h9abc_def0);
    tick();
    n_total++;
    if ({addr_o, inst_o, valid_o} !== {32'h0, 32'h0, 1'b0})
      $display("FAIL reset_held_edge: got %h/%h/%b expected 0/0/0", addr_o, inst_o, valid_o);
    else n_pass++;
    rst_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h1111_2222, 32'h3333_4444);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_total++;
      if ({addr_o, inst_o, valid_o} !== {32'h0, 32'h0, 1'b0})
        $display("FAIL startup_hold[%0d]: got %h/%h/%b expected 0/0/0", i, addr_o, inst_o, valid_o);
      else n_pass++;
    end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'(7 + i), 32'(i));
      tick();
      n_total++;
      if ({addr_o, inst_o, valid_o} !== {32'(7 + i), 32'(i), 1'b1})
        $display("FAIL stream[%0d]: got %h/%h/%b expected %h/%h/1",
                 i, addr_o, inst_o, valid_o, 32'(7 + i), 32'(i));
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    // Outputs hold 12/5 from the stream; inputs keep advancing during stall.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'(13 + i), 32'(6 + i));
      tick();
      n_total++;
      if ({addr_o, inst_o, valid_o} !== {32'd12, 32'd5, 1'b1})
        $display("FAIL stall[%0d]: got %h/%h/%b expected 0000000c/00000005/1",
                 i, addr_o, inst_o, valid_o);
      else n_pass++;
    end
    drive(1'b1, 1'b0, 1'b0, 32'd15, 32'd8);
    tick();
    n_total++;
    if ({addr_o, inst_o, valid_o} !== {32'd15, 32'd8, 1'b1})
      $display("FAIL stall_resume: got %h/%h/%b expected 0000000f/00000008/1",
               addr_o, inst_o, valid_o);
    else n_pass++;
  endtask

  task automatic test_flush();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, k[0], 1'b1, 32'hdead_beef, 32'hcafe_f00d);
      tick();
      n_total++;
      if ({addr_o, inst_o, valid_o} !== {32'h0, 32'h0, 1'b0})
        $display("FAIL flush(stall=%0d): got %h/%h/%b expected 0/0/0", k, addr_o, inst_o, valid_o);
      else n_pass++;
      drive(1'b1, 1'b0, 1'b0, 32'(32'h100 + k), 32'(32'h200 + k));
      tick();
      n_total++;
      if ({addr_o, inst_o, valid_o} !== {32'(32'h100 + k), 32'(32'h200 + k), 1'b1})
        $display("FAIL flush_recover(stall=%0d): got %h/%h/%b expected %h/%h/1",
                 k, addr_o, inst_o, valid_o, 32'(32'h100 + k), 32'(32'h200 + k));
      else n_pass++;
    end
    // Run enable low masks a flush request.
    drive(1'b0, 1'b1, 1'b1, 32'h0bad_0bad, 32'h0bad_0bad);
    tick();
    n_total++;
    if ({addr_o, inst_o, valid_o} !== {32'h101, 32'h201, 1'b1})
      $display("FAIL flush_masked_by_start: got %h/%h/%b expected 00000101/00000201/1",
               addr_o, inst_o, valid_o);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0000_000a, 32'h0000_0042);
    tick();
    n_total++;
    if (addr_o !== 32'h0000_000a)
      $display("FAIL areset_setup: got %h expected 0000000a", addr_o);
    else n_pass++;
    #2 rst_i = 1'b1;
    exp_addr = '0; exp_inst = '0; exp_valid = 1'b0;
    #1;
    n_total++;
    if ({addr_o, inst_o, valid_o} !== {32'h0, 32'h0, 1'b0})
      $display("FAIL areset_mid_cycle: got %h/%h/%b expected 0/0/0", addr_o, inst_o, valid_o);
    else n_pass++;
    tick();
    rst_i = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0000_0055, 32'h0000_0066);
    tick();
    n_total++;
    if ({addr_o, inst_o, valid_o} !== {32'h55, 32'h66, 1'b1})
      $display("FAIL areset_release: got %h/%h/%b expected 00000055/00000066/1",
               addr_o, inst_o, valid_o);
    else n_pass++;
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b0, 1'b0, 32'hffff_ffff, 32'hffff_ffff);
    tick();
    n_total++;
    if ({addr_o, inst_o, valid_o} !== {32'hffff_ffff, 32'hffff_ffff, 1'b1})
      $display("FAIL wrap_ones: got %h/%h/%b expected ffffffff/ffffffff/1", addr_o, inst_o, valid_o);
    else n_pass++;
    drive(1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h8000_0001);
    tick();
    n_total++;
    if ({addr_o, inst_o, valid_o} !== {32'h0, 32'h8000_0001, 1'b1})
      $display("FAIL wrap_zero: got %h/%h/%b expected 00000000/80000001/1", addr_o, inst_o, valid_o);
    else n_pass++;
  endtask

  task automatic test_input_glitch();
    for (int i = 0; i < 3; i++) begin
      #2 drive(1'b1, 1'b0, 1'(i == 1), $urandom, $urandom);
      n_total++;
      if ({addr_o, inst_o, valid_o} !== {32'h0, 32'h8000_0001, 1'b1})
        $display("FAIL glitch[%0d]: got %h/%h/%b expected 00000000/80000001/1",
                 i, addr_o, inst_o, valid_o);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 5) == 0), $urandom, $urandom);
      tick();
      n_total++;
      if ({addr_o, inst_o, valid_o} !== {exp_addr, exp_inst, exp_valid})
        $display("FAIL random[%0d]: got %h/%h/%b expected %h/%h/%b",
                 i, addr_o, inst_o, valid_o, exp_addr, exp_inst, exp_valid);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_async_reset();
    test_wrap();
    test_input_glitch();
    tick();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_id_reg.md
Name: if_id_reg

Overview:
- IF/ID pipeline register of the 5-stage pipelined CPU.
- Captures the fetched instruction address and instruction word at each rising clock edge and presents them to the decode stage one cycle later.
- Supports a global start enable, a hazard-unit stall (hold) and a branch/jump flush (bubble insertion).
- Outputs are registered only; there is no combinational path from input to output.

Parameters:
- ADDR_WIDTH, 32, width of the instruction address path.
- INST_WIDTH, 32, width of the instruction word.
- NOP_INST, 0, instruction word loaded on flush and reset (all-zero encodes NOP).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  pipeline run enable; 0 = register holds its contents.
- stall_i  input  1  hazard stall; 1 = hold current contents.
- flush_i  input  1  flush; 1 = load a bubble.
- addr_i  input  ADDR_WIDTH  address of the fetched instruction, from IF.
- inst_i  input  INST_WIDTH  fetched instruction word, from instruction memory.
- addr_o  output  ADDR_WIDTH  registered address, to ID.
- inst_o  output  INST_WIDTH  registered instruction, to ID.
- valid_o  output  1  1 = inst_o holds a real fetched instruction; 0 = bubble/reset.

Behaviour:
- Reset: rst_i high forces the following immediately, with no clock edge required, and holds them while rst_i stays high:
  - addr_o = 0
  - inst_o = NOP_INST
  - valid_o = 0
- Reset mid-operation discards the captured instruction. The first capture after release occurs at the first rising edge with rst_i low.
- At each rising edge with rst_i low, exactly one action is taken, in priority order:
  1. start_i = 0: hold all outputs unchanged. Stall and flush are ignored.
  2. flush_i = 1: addr_o <= 0, inst_o <= NOP_INST, valid_o <= 0. Flush wins over a simultaneous stall_i.
  3. stall_i = 1: hold all outputs unchanged. Inputs are ignored.
  4. Otherwise: addr_o <= addr_i, inst_o <= inst_i, valid_o <= 1.
- Latency: exactly 1 cycle from input to output in normal operation.
- Throughput: one instruction per cycle.
- Widths:
  - Values pass through bit-exact; no arithmetic, no sign or zero extension.
  - Address wrap-around (e.g. all-ones followed by 0) is passed through unchanged.
- Outputs change only on a clock edge or on reset assertion. Changing inputs between edges has no effect on the outputs.
- No X propagation from the register itself: every output bit has a defined reset value.

Test Plan:
1. Reset/start-up:
   - Stimulus: rst_i=1 with no clock edge, then release; keep start_i=0 for 2 cycles.
   - Required: addr_o=0, inst_o=0, valid_o=0 immediately on reset and throughout.
2. Streaming:
   - Stimulus: start_i=1, stall_i=0, flush_i=0; addr_i starts at 7 and inst_i at 0, both incrementing by 1 each cycle.
   - Required: after each edge, addr_o/inst_o equal the values sampled at that edge (7/0, then 8/1, then 9/2, ...), and valid_o=1.
3. Stall:
   - Stimulus: while streaming, stall_i=1 for 2 cycles with inputs still changing.
   - Required: outputs frozen at the pre-stall values; capture resumes on the first edge after stall_i drops.
4. Flush:
   - Stimulus: flush_i=1 for 1 cycle, including one case with stall_i=1 at the same time.
   - Required: addr_o=0, inst_o=0, valid_o=0 after that edge; the next edge captures the new inputs.
5. Async reset mid-stream:
   - Stimulus: assert rst_i between clock edges while addr_o=0x0000000A.
   - Required: outputs go to 0/0/0 before the next edge; normal capture after release.
6. Wrap-around:
   - Stimulus: addr_i=0xFFFFFFFF then 0x00000000.
   - Required: addr_o reproduces both values bit-exact on successive edges.
